// File: rtl/icache_load_ctrl_pkg.sv
// Shared types and constants for the instruction-cache load controller.
package icache_load_ctrl_pkg;

  localparam int unsigned INSN_W = 32;
  localparam logic [INSN_W-1:0] NOP_WORD_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

endpackage

// File: rtl/icache_fetch_pipe.sv
// Fetch result pipeline: tracks RD_LAT cycles of read validity and the beyond-image flag.
module icache_fetch_pipe
  import icache_load_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 9,
  parameter int unsigned       RD_LAT   = 1,
  parameter logic [INSN_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [ADDR_W:0]   limit,
  input  logic [INSN_W-1:0] ram_q,
  output logic              out_valid,
  output logic [INSN_W-1:0] out_data
);

  logic [RD_LAT-1:0] v_sr;
  logic [RD_LAT-1:0] nop_sr;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      v_sr   <= '0;
      nop_sr <= '0;
    end else if (flush) begin
      v_sr   <= '0;
      nop_sr <= '0;
    end else begin
      v_sr[0]   <= in_valid;
      nop_sr[0] <= ({1'b0, in_addr} >= limit);
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        v_sr[i]   <= v_sr[i-1];
        nop_sr[i] <= nop_sr[i-1];
      end
    end
  end

  // ram_q is only valid in the result cycle, so the data mux follows the registered flags.
  assign out_valid = v_sr[RD_LAT-1];

  always_comb begin
    out_data = '0;
    if (out_valid) out_data = nop_sr[RD_LAT-1] ? NOP_WORD : ram_q;
  end

endmodule

// File: rtl/icache_load_ctrl.sv
// Program-load sequencer and fetch arbiter for the instruction cache RAM.
// Define ICACHE_CKSUM_EN to verify a running 32-bit word checksum on ld_last.
module icache_load_ctrl
  import icache_load_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 9,
  parameter int unsigned       RD_LAT   = 1,
  parameter int unsigned       TIMEOUT  = 65535,
  parameter logic [INSN_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              ld_valid,
  input  logic [INSN_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [INSN_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              cpu_hold,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [INSN_W-1:0] ram_wdata,
  output logic              ram_rden,
  output logic [ADDR_W-1:0] ram_rdaddr,
  input  logic [INSN_W-1:0] ram_q,
  output logic [ADDR_W:0]   load_words,
  output logic              load_ovf,
  output logic              load_err
);

  localparam int unsigned     TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] idle_cnt;
  logic            in_load, wr_word, accept, drop, ovf_base, cksum_ok, last_ok, timed_out;
  logic [ADDR_W:0] cnt_base, cnt_next;
`ifdef ICACHE_CKSUM_EN
  logic [INSN_W-1:0] sum, sum_base;
`endif

  // A start word seen in IDLE/RUN is processed as a LOAD word against a cleared image.
  always_comb begin
    in_load  = (state == LOAD) || ld_valid;
    cnt_base = (state == LOAD) ? load_words : '0;
    ovf_base = (state == LOAD) && load_ovf;
`ifdef ICACHE_CKSUM_EN
    sum_base = (state == LOAD) ? sum : '0;
    wr_word  = ld_valid && !ld_last;
    cksum_ok = (ld_data == sum_base);
`else
    wr_word  = ld_valid;
    cksum_ok = 1'b1;
`endif
    accept    = wr_word && !cnt_base[ADDR_W];
    drop      = wr_word && cnt_base[ADDR_W];
    cnt_next  = cnt_base + {{ADDR_W{1'b0}}, accept};
    last_ok   = (cnt_next != '0) && cksum_ok;
    timed_out = !ld_valid && !ld_last && (idle_cnt == TO_LAST);
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state      <= IDLE;
      cpu_hold   <= 1'b1;
      ram_wren   <= 1'b0;
      ram_wraddr <= '0;
      ram_wdata  <= '0;
      ram_rden   <= 1'b0;
      ram_rdaddr <= '0;
      load_words <= '0;
      load_ovf   <= 1'b0;
      load_err   <= 1'b0;
      idle_cnt   <= '0;
`ifdef ICACHE_CKSUM_EN
      sum        <= '0;
`endif
    end else begin
      ram_wren <= 1'b0;
      ram_rden <= 1'b0;
      if (in_load) begin
        ram_wren <= accept;
        if (accept) begin
          ram_wraddr <= cnt_base[ADDR_W-1:0];
          ram_wdata  <= ld_data;
        end
        load_words <= cnt_next;
        load_ovf   <= ovf_base || drop;
        idle_cnt   <= (ld_valid || ld_last) ? '0 : idle_cnt + 1'b1;
        if (state != LOAD) load_err <= 1'b0;
`ifdef ICACHE_CKSUM_EN
        sum <= sum_base + (accept ? ld_data : '0);
`endif
        if (ld_last) begin
          state    <= last_ok ? RUN : IDLE;
          cpu_hold <= !last_ok;
          if (!last_ok) load_err <= 1'b1;
        end else if (timed_out) begin
          state    <= IDLE;
          cpu_hold <= 1'b1;
          load_err <= 1'b1;
        end else begin
          state    <= LOAD;
          cpu_hold <= 1'b1;
        end
      end else if (state == RUN) begin
        cpu_hold <= 1'b0;
        ram_rden <= fetch_req;
        if (fetch_req) ram_rdaddr <= fetch_addr;
      end
    end
  end

  icache_fetch_pipe #(
    .ADDR_W   (ADDR_W),
    .RD_LAT   (RD_LAT),
    .NOP_WORD (NOP_WORD)
  ) u_fetch_pipe (
    .clock     (clock),
    .aclr      (aclr),
    .flush     ((state != RUN) || ld_valid),
    .in_valid  (ram_rden),
    .in_addr   (ram_rdaddr),
    .limit     (load_words),
    .ram_q     (ram_q),
    .out_valid (fetch_valid),
    .out_data  (fetch_data)
  );

endmodule

// File: tb/tb_icache_load_ctrl.sv
// Randomized bench for icache_load_ctrl: behavioural image/fetch model plus a bench-side RAM.
module tb_icache_load_ctrl;
  import icache_load_ctrl_pkg::*;

  localparam int AW    = 9;
  localparam int RDL   = 2;
  localparam int TO    = 16;
  localparam int DEPTH = 1 << AW;
`ifdef ICACHE_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          aclr = 1'b1;
  logic          ld_valid = 1'b0, ld_last = 1'b0, fetch_req = 1'b0;
  logic [31:0]   ld_data = '0;
  logic [AW-1:0] fetch_addr = '0;
  logic [31:0]   fetch_data, ram_wdata, ram_q;
  logic          fetch_valid, cpu_hold, ram_wren, ram_rden, load_ovf, load_err;
  logic [AW-1:0] ram_wraddr, ram_rdaddr;
  logic [AW:0]   load_words;

  icache_load_ctrl #(.ADDR_W(AW), .RD_LAT(RDL), .TIMEOUT(TO)) dut (
    .clock(clock), .aclr(aclr), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_valid(fetch_valid), .cpu_hold(cpu_hold), .ram_wren(ram_wren),
    .ram_wraddr(ram_wraddr), .ram_wdata(ram_wdata), .ram_rden(ram_rden),
    .ram_rdaddr(ram_rdaddr), .ram_q(ram_q), .load_words(load_words),
    .load_ovf(load_ovf), .load_err(load_err)
  );

  always #5 clock = ~clock;

  // Bench-side RAM with RDL-cycle registered read.
  logic [31:0]   mem [DEPTH];
  logic [31:0]   qp  [RDL];
  logic [AW-1:0] wa_log [$];
  logic [31:0]   wd_log [$];
  always @(posedge clock) begin
    if (ram_wren) begin
      mem[ram_wraddr] <= ram_wdata;
      wa_log.push_back(ram_wraddr);
      wd_log.push_back(ram_wdata);
    end
    if (ram_rden) qp[0] <= mem[ram_rdaddr];
    for (int i = 1; i < RDL; i++) qp[i] <= qp[i-1];
  end
  assign ram_q = qp[RDL-1];

  // Behavioural model: image contents, counters and a cycle-indexed table of fetch results.
  bit            loading, running, ovf, err, e_wren, e_rden, e_hold;
  int            words, idle, cyc;
  logic [31:0]   sum, e_wdata;
  logic [AW-1:0] e_wraddr, e_rdaddr;
  logic [31:0]   img [DEPTH];
  logic [31:0]   sched [int];
  int            n_cmp = 0, n_bad = 0;

  function automatic void model_reset();
    loading = 0; running = 0; ovf = 0; err = 0; words = 0; idle = 0; sum = '0;
    e_wren = 0; e_rden = 0; e_hold = 1; e_wdata = '0; e_wraddr = '0; e_rdaddr = '0;
    sched.delete();
  endfunction

  // Predicts the outputs visible after the coming rising edge from the inputs now driven.
  function automatic void model_step();
    cyc++;
    e_wren = 0; e_rden = 0;
    if (loading || ld_valid) begin
      if (!loading) begin
        sched.delete();
        loading = 1; running = 0; words = 0; ovf = 0; err = 0; sum = '0; idle = 0;
      end
      if (ld_valid && !(CK && ld_last)) begin
        if (words < DEPTH) begin
          img[words] = ld_data; e_wren = 1; e_wraddr = AW'(words); e_wdata = ld_data;
          words++; sum = sum + ld_data;
        end else ovf = 1;
      end
      idle = (ld_valid || ld_last) ? 0 : idle + 1;
      if (ld_last) begin
        loading = 0;
        running = (words > 0) && (!CK || ld_data == sum);
        err = !running;
      end else if (idle >= TO) begin
        loading = 0; err = 1;
      end
    end else if (running && fetch_req) begin
      e_rden = 1; e_rdaddr = fetch_addr;
      sched[cyc + RDL] = (int'(fetch_addr) < words) ? img[fetch_addr] : NOP_WORD_DEF;
    end
    e_hold = !running;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void check_all();
    logic        efv;
    logic [31:0] efd;
    efv = sched.exists(cyc);
    efd = efv ? sched[cyc] : '0;
    chk("cpu_hold", cpu_hold, e_hold);
    chk("ram_wren", ram_wren, e_wren);
    chk("ram_wraddr", ram_wraddr, e_wraddr);
    chk("ram_wdata", ram_wdata, e_wdata);
    chk("ram_rden", ram_rden, e_rden);
    chk("ram_rdaddr", ram_rdaddr, e_rdaddr);
    chk("load_words", load_words, 64'(words));
    chk("load_ovf", load_ovf, ovf);
    chk("load_err", load_err, err);
    chk("fetch_valid", fetch_valid, efv);
    chk("fetch_data", fetch_data, efd);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  task automatic drive_idle();
    ld_valid = 0; ld_last = 0; ld_data = $urandom;
    fetch_req = $urandom_range(0, 1); fetch_addr = AW'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input bit last);
    drive_idle(); ld_valid = 1; ld_data = w; ld_last = last; tick();
  endtask

  task automatic send_last(input logic [31:0] d);
    drive_idle(); ld_last = 1; ld_data = d; tick();
  endtask

  task automatic gap(input int n);
    repeat (n) begin drive_idle(); tick(); end
  endtask

  task automatic fetch_one(input logic [AW-1:0] a);
    drive_idle(); fetch_req = 1; fetch_addr = a; tick();
    repeat (RDL) begin drive_idle(); fetch_req = 0; tick(); end
  endtask

  task automatic load_list(input logic [31:0] ws[$], input bit combine, input logic [31:0] lastd);
    foreach (ws[i]) begin
      gap($urandom_range(0, 2));
      send_word(ws[i], combine && (i == ws.size() - 1));
    end
    if (!combine) begin gap($urandom_range(0, 2)); send_last(lastd); end
  endtask

  task automatic fetch_burst(input int n, input int maxaddr);
    repeat (n) begin
      drive_idle();
      fetch_req  = ($urandom_range(0, 3) != 0);
      fetch_addr = AW'($urandom_range(0, maxaddr));
      ld_last    = ($urandom_range(0, 9) == 0);
      tick();
    end
  endtask

  task automatic do_reset();
    #2 aclr = 1;
    model_reset();
    #1 check_all();
    chk("rst_wren", ram_wren, 0);
    chk("rst_rden", ram_rden, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_words", load_words, 0);
    @(posedge clock);
    @(negedge clock);
    check_all();
    chk("rst_wren_edge", ram_wren, 0);
    ld_valid = 0; ld_last = 0; fetch_req = 0;
    aclr = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] s;
    int n;
    model_reset();
    cyc = 0;
    @(negedge clock); @(negedge clock);
    check_all();
    chk("init_hold", cpu_hold, 1);
    chk("init_fdata", fetch_data, 0);
    aclr = 0;

    repeat (4) begin drive_idle(); fetch_req = 1; fetch_addr = '0; tick(); end
    chk("idle_fv", fetch_valid, 0);
    chk("idle_hold", cpu_hold, 1);

    wa_log.delete(); wd_log.delete();
    send_word(32'h11, 0); gap(1); send_word(32'h22, 0);
    send_word(32'h33, 0); gap(2); send_word(32'h44, 0);
    chk("hold_before_last", cpu_hold, 1);
    send_last(32'hAA);
    chk("hold_after_last", cpu_hold, 0);
    chk("words4", load_words, 4);
    chk("wr_count", wa_log.size(), 4);
    for (int i = 0; i < 4 && i < wa_log.size(); i++) begin
      chk("wr_addr", wa_log[i], i);
      chk("wr_data", wd_log[i], 32'h11 * (i + 1));
    end
    fetch_one(AW'(2));
    chk("fetch2_valid", fetch_valid, 1);
    chk("fetch2_data", fetch_data, 32'h33);
    fetch_one(AW'(7));
    chk("fetch7_data", fetch_data, 32'h13);

    drive_idle(); fetch_req = 1; fetch_addr = AW'(1); tick();
    do_reset();
    send_word(32'h5, 1);
`ifdef ICACHE_CKSUM_EN
    chk("combo_err", load_err, 1);
    chk("combo_hold", cpu_hold, 1);
`else
    chk("combo_words", load_words, 1);
    chk("combo_hold", cpu_hold, 0);
`endif
    gap(2);

    wa_log.delete(); wd_log.delete();
    for (int i = 0; i < DEPTH + 1; i++) send_word(32'(i + 1), 0);
    send_last(32'd131328);
    chk("ovf_words", load_words, DEPTH);
    chk("ovf_flag", load_ovf, 1);
    chk("ovf_hold", cpu_hold, 0);
    chk("ovf_writes", wa_log.size(), DEPTH);

    send_word(32'h77, 0);
    gap(TO + 2);
    chk("to_err", load_err, 1);
    chk("to_hold", cpu_hold, 1);
    send_word(32'h88, 0);
    chk("to_err_clear", load_err, 0);
    send_last(32'h88);
    chk("to_reload_hold", cpu_hold, 0);

`ifdef ICACHE_CKSUM_EN
    q = {32'd1, 32'd2, 32'd3};
    load_list(q, 0, 32'd6);
    chk("ck_ok_hold", cpu_hold, 0);
    chk("ck_ok_err", load_err, 0);
    load_list(q, 0, 32'd7);
    chk("ck_bad_err", load_err, 1);
    chk("ck_bad_hold", cpu_hold, 1);
`endif

    repeat (8) begin
      n = $urandom_range(2, 20);
      q = {};
      s = '0;
      repeat (n) begin q.push_back($urandom); s = s + q[$]; end
      load_list(q, CK ? 1'b0 : 1'($urandom_range(0, 1)), s);
      fetch_burst(40, n + 4);
    end

    send_word($urandom, 0); send_word($urandom, 0);
    drive_idle(); ld_valid = 1; ld_data = 32'hDEAD;
    do_reset();
    gap(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_load_ctrl.md
Name: icache_load_ctrl

Overview:
- Sequences the UDP program-load path into the 32-bit instruction cache RAM (dual-port, 9-bit address, registered read).
- Arbitrates the cache between the UDP loader (write side) and CPU instruction fetch (read side).
- Holds the CPU in reset while a program image is loading. Releases it only after a clean end-of-load.
- Sits between the UDP receiver word stream (already synchronised to `clock`) and the RAM/CPU fetch port.

Parameters:
- ADDR_W, 9, RAM word-address width; depth = 2**ADDR_W words.
- RD_LAT, 1, RAM read latency in cycles (rden to q valid).
- TIMEOUT, 65535, idle cycles allowed in LOAD before the load is aborted.
- NOP_WORD, 32'h00000013, word returned for a fetch beyond the loaded image.

Ports:
- clock in 1: single system clock; all logic on rising edge.
- aclr in 1: asynchronous, active-high reset.
- ld_valid in 1: one-cycle strobe, one program word on ld_data.
- ld_data in 32: program word, or expected checksum (feature only).
- ld_last in 1: one-cycle end-of-image strobe.
- fetch_req in 1: CPU fetch request.
- fetch_addr in ADDR_W: CPU word address.
- fetch_data out 32: fetched instruction.
- fetch_valid out 1: fetch_data valid.
- cpu_hold out 1: CPU reset/stall.
- ram_wren out 1: RAM write enable.
- ram_wraddr out ADDR_W: RAM write address.
- ram_wdata out 32: RAM write data.
- ram_rden out 1: RAM read enable.
- ram_rdaddr out ADDR_W: RAM read address.
- ram_q in 32: RAM read data.
- load_words out ADDR_W+1: words in the current image.
- load_ovf out 1: sticky flag, image exceeded depth.
- load_err out 1: sticky flag, load aborted.

Behaviour:
- Reset values, asserted asynchronously on aclr:
  - State goes to IDLE.
  - cpu_hold=1.
  - All other outputs are 0, including fetch_data, load_words, load_ovf and load_err.
- All outputs are registered.
- State IDLE:
  - cpu_hold=1 and fetch is ignored.
  - ld_valid goes to LOAD and writes that word at address 0.
- State LOAD:
  - On entry, clear load_words, load_ovf and load_err.
  - cpu_hold=1.
  - Each ld_valid:
    - If load_words < 2**ADDR_W: next cycle drive ram_wren=1, ram_wraddr=load_words[ADDR_W-1:0], ram_wdata=ld_data, then increment load_words.
    - Otherwise drop the word and set load_ovf.
  - ld_last:
    - load_words > 0 goes to RUN.
    - load_words == 0 goes to IDLE with load_err=1.
  - ld_valid and ld_last in the same cycle: write the word first, then evaluate ld_last using the incremented count.
  - No ld_valid or ld_last for TIMEOUT consecutive cycles goes to IDLE with load_err=1.
- State RUN:
  - cpu_hold=0 from the cycle after entry.
  - fetch_req produces ram_rden=1 and ram_rdaddr=fetch_addr on the next cycle.
  - fetch_valid pulses RD_LAT+1 cycles after fetch_req, with fetch_data=ram_q.
  - If the latched fetch_addr >= load_words, fetch_data=NOP_WORD instead of ram_q.
  - Back-to-back fetch_req is supported, one result per cycle.
  - ld_valid in RUN starts a new load:
    - Go to LOAD and set cpu_hold=1 on the next cycle.
    - Write the word at address 0.
    - A fetch_req in that same cycle is dropped.
    - In-flight fetch_valid pulses are suppressed.
- ld_last outside LOAD is ignored.
- Reset mid-load: image is discarded, IDLE, cpu_hold=1.
- ram_wren and ram_rden are never 1 in the same cycle, because load and run are exclusive.

Optional Feature:
- Macro ICACHE_CKSUM_EN.
- When defined:
  - Keep a 32-bit running modulo-2^32 sum of accepted (non-dropped) words.
  - On ld_last (with ld_valid=0), compare ld_data to the sum.
  - Mismatch goes to IDLE with load_err=1, even if load_words > 0.
  - ld_valid and ld_last together: compare only, ld_data is not written.
- When undefined:
  - ld_data is ignored on ld_last-only cycles.
  - No sum register is built.

Decomposition:
- Shared package holds:
  - State enum {IDLE, LOAD, RUN}.
  - NOP_WORD default.
  - Width constant for 32-bit instruction words.
- One sub-module, icache_fetch_pipe: RD_LAT-deep valid/address-compare shift pipeline with flush input. Used for fetch_valid, fetch_data mux and suppression.

Test Plan:
- Reset then fetch_req=1, addr 0 -> fetch_valid stays 0, cpu_hold=1.
- Load 4 words (0x11,0x22,0x33,0x44) then ld_last:
  - ram writes at addr 0..3.
  - load_words=4.
  - cpu_hold falls one cycle after ld_last.
  - fetch addr 2 gives fetch_data=0x33 RD_LAT+1 cycles later.
  - fetch addr 7 gives 0x00000013.
- ld_valid and ld_last in the same cycle with 1 word -> load_words=1, RUN.
- Load 513 words with ADDR_W=9 -> 512 writes, load_ovf=1, RUN after ld_last, load_words=512.
- Start a load, then stall longer than TIMEOUT (set to 16) -> IDLE, load_err=1, cpu_hold=1. A next ld_valid clears load_err.
- ICACHE_CKSUM_EN with words 1,2,3 then ld_last with ld_data=6 -> RUN. Repeat with ld_data=7 -> IDLE, load_err=1.
- Assert aclr mid-load and mid-fetch -> all outputs at reset values immediately, no stray ram_wren.
